// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and helpers for the keypad scan controller: FSM states, keymap, column drive.
// Pure combinational helpers, no state.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE_PRESS,
        HELD,
        DEBOUNCE_RELEASE
    } state_t;

    function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] hex;
        case ({row_idx, col_idx})
            4'h0: hex = 4'h1;
            4'h1: hex = 4'h2;
            4'h2: hex = 4'h3;
            4'h3: hex = 4'hA;
            4'h4: hex = 4'h4;
            4'h5: hex = 4'h5;
            4'h6: hex = 4'h6;
            4'h7: hex = 4'hB;
            4'h8: hex = 4'h7;
            4'h9: hex = 4'h8;
            4'hA: hex = 4'h9;
            4'hB: hex = 4'hC;
            4'hC: hex = 4'hE;
            4'hD: hex = 4'h0;
            4'hE: hex = 4'hF;
            default: hex = 4'hD;
        endcase
        return hex;
    endfunction

    function automatic logic [3:0] col_onehot_n(input logic [1:0] col_idx);
        return ~(4'b0001 << col_idx);
    endfunction

    // Rows are active-low; the lowest-numbered low row wins.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        if (!rows[0]) return 2'd0;
        if (!rows[1]) return 2'd1;
        if (!rows[2]) return 2'd2;
        return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad matrix lines plus the key event bus toward the number bank / seven-segment path.
// Events are single-cycle pulses with no backpressure; code and hex are held between events.
interface keypad_scan_ctrl_if;
    logic [3:0] row_sync;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] key_hex;
    logic       key_held;

    modport master (
        input  row_sync,
        output col_n, key_valid, key_code, key_hex, key_held
    );

    modport slave (
        output row_sync,
        input  col_n, key_valid, key_code, key_hex, key_held
    );
endinterface

// File: rtl/keypad_scan_ctrl_cycle_timer.sv
// Loadable up-counter with clear and enable; done flags count == cmp (combinational).
// Priority clr > load > en; no backpressure.
module cycle_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic [CNT_W-1:0] cmp,
    output logic             done
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= count + 1'b1;
    end

    assign done = (count == cmp);
endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column sequencing, press/release debounce, one event per physical press.
// key_valid lands DEBOUNCE_CYCLES cycles after the scan sample that saw the row low; no backpressure.
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES     = 15,
    parameter int DEBOUNCE_CYCLES = 150000,
    parameter int CNT_W           = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    keypad_scan_ctrl_if.master   bus
);
    import keypad_pkg::*;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_FIRST  = CNT_W'(1);
    localparam bit               DEB_ONE    = (DEBOUNCE_CYCLES == 1);

    state_t     state, state_nxt;
    logic [1:0] col_idx, col_nxt;
    logic [1:0] row_idx, row_nxt;
    logic [1:0] row_pick;
    logic [3:0] code_q, code_nxt;
    logic [3:0] hex_q, hex_nxt;
    logic       valid_q, valid_nxt;
    logic       any_low, row_low;
    logic       dwell_clr, dwell_en, dwell_done;
    logic       deb_load, deb_en, deb_done;

    assign any_low  = ~&bus.row_sync;
    assign row_low  = ~bus.row_sync[row_idx];
    assign row_pick = lowest_low_row(bus.row_sync);

    cycle_timer #(.CNT_W(CNT_W)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .clr      (dwell_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (dwell_en),
        .cmp      (DWELL_LAST),
        .done     (dwell_done)
    );

    // The reading that triggers entry into a debounce state counts as its first stable cycle.
    cycle_timer #(.CNT_W(CNT_W)) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .clr      (1'b0),
        .load     (deb_load),
        .load_val (DEB_FIRST),
        .en       (deb_en),
        .cmp      (DEB_LAST),
        .done     (deb_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
            code_q  <= 4'd0;
            hex_q   <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            col_idx <= col_nxt;
            row_idx <= row_nxt;
            code_q  <= code_nxt;
            hex_q   <= hex_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col_idx;
        row_nxt   = row_idx;
        code_nxt  = code_q;
        hex_nxt   = hex_q;
        valid_nxt = 1'b0;
        dwell_clr = 1'b0;
        dwell_en  = 1'b0;
        deb_load  = 1'b0;
        deb_en    = 1'b0;

        case (state)
            SCAN: begin
                if (!dwell_done) begin
                    dwell_en = 1'b1;
                end else begin
                    dwell_clr = 1'b1;
                    if (!any_low) begin
                        col_nxt = col_idx + 2'd1;
                    end else begin
                        row_nxt = row_pick;
                        if (DEB_ONE) begin
                            valid_nxt = 1'b1;
                            code_nxt  = {row_pick, col_idx};
                            hex_nxt   = keymap(row_pick, col_idx);
                            state_nxt = HELD;
                        end else begin
                            deb_load  = 1'b1;
                            state_nxt = DEBOUNCE_PRESS;
                        end
                    end
                end
            end

            DEBOUNCE_PRESS: begin
                if (!row_low) begin
                    col_nxt   = col_idx + 2'd1;
                    state_nxt = SCAN;
                end else if (deb_done) begin
                    valid_nxt = 1'b1;
                    code_nxt  = {row_idx, col_idx};
                    hex_nxt   = keymap(row_idx, col_idx);
                    state_nxt = HELD;
                end else begin
                    deb_en = 1'b1;
                end
            end

            HELD: begin
                if (!row_low) begin
                    if (DEB_ONE) begin
                        col_nxt   = col_idx + 2'd1;
                        state_nxt = SCAN;
                    end else begin
                        deb_load  = 1'b1;
                        state_nxt = DEBOUNCE_RELEASE;
                    end
                end
            end

            DEBOUNCE_RELEASE: begin
                if (row_low) begin
                    state_nxt = HELD;
                end else if (deb_done) begin
                    col_nxt   = col_idx + 2'd1;
                    state_nxt = SCAN;
                end else begin
                    deb_en = 1'b1;
                end
            end

            default: state_nxt = SCAN;
        endcase
    end

    assign bus.col_n     = col_onehot_n(col_idx);
    assign bus.key_valid = valid_q;
    assign bus.key_code  = code_q;
    assign bus.key_hex   = hex_q;
    assign bus.key_held  = (state == HELD) || (state == DEBOUNCE_RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, table-driven key vectors, corner sequences
// and a randomized run checked every cycle against a run-length reference model.
module tb_keypad_scan_ctrl;
    localparam int S = 4;
    localparam int D = 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pmask = '0;   // bit r*4+c set: key at row r, column c is physically closed

    keypad_scan_ctrl_if bus();

    keypad_scan_ctrl #(.SCAN_CYCLES(S), .DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.row_sync = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pmask[r*4+c] && !bus.col_n[c]) bus.row_sync[r] = 1'b0;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: scan position is pure arithmetic from the cycle the scan (re)started;
    // debounce is a run length of consecutive identical readings of the locked key.
    int cyc, scan_base, base_col, mode, run, lk_r, lk_c, m_pulses, dut_pulses;
    logic [3:0] m_code, m_hex;
    logic       m_valid;
    logic [3:0] hexmap [16];
    logic [3:0] colseq [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (cyc %0d): got %0h want %0h", name, cyc, got, exp);
        end
    endtask

    function automatic int model_col();
        if (mode == 0) return (base_col + (cyc - scan_base) / S) % 4;
        return lk_c;
    endfunction

    task automatic model_init();
        cyc = 0; scan_base = 0; base_col = 0; mode = 0; run = 0;
        m_valid = 1'b0; m_code = 4'h0; m_hex = 4'h0;
    endtask

    task automatic model_adv();
        int  c, lr;
        logic lk;
        c = model_col();
        m_valid = 1'b0;
        lk = pmask[lk_r*4+lk_c];
        case (mode)
            0: if ((cyc - scan_base) % S == S - 1) begin
                lr = -1;
                for (int r = 3; r >= 0; r--) if (pmask[r*4+c]) lr = r;
                if (lr >= 0) begin lk_r = lr; lk_c = c; mode = 1; run = 1; end
            end
            1: if (lk) begin
                run++;
                if (run == D) begin
                    m_valid = 1'b1; m_pulses++;
                    m_code = 4'(lk_r*4 + lk_c);
                    m_hex  = hexmap[lk_r*4+lk_c];
                    mode = 2;
                end
            end else begin
                mode = 0; base_col = (lk_c + 1) % 4; scan_base = cyc + 1;
            end
            2: if (!lk) begin mode = 3; run = 1; end
            default: if (!lk) begin
                run++;
                if (run == D) begin mode = 0; base_col = (lk_c + 1) % 4; scan_base = cyc + 1; end
            end else begin
                mode = 2;
            end
        endcase
        cyc++;
    endtask

    task automatic check_outputs();
        logic [3:0] ecol;
        logic       eheld;
        ecol = 4'hF;
        ecol[model_col()] = 1'b0;
        eheld = (mode == 2) || (mode == 3);
        check("outputs{col_n,valid,held,code,hex}",
              {bus.col_n, bus.key_valid, bus.key_held, bus.key_code, bus.key_hex},
              {ecol, m_valid, eheld, m_code, m_hex});
        if (bus.key_valid === 1'b1) dut_pulses++;
    endtask

    task automatic step();
        model_adv();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run_steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        check("reset_col_n", bus.col_n, 4'b1110);
        check("reset_key_valid", bus.key_valid, 1'b0);
        check("reset_key_code", bus.key_code, 4'h0);
        check("reset_key_hex", bus.key_hex, 4'h0);
        check("reset_key_held", bus.key_held, 1'b0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_init();
        check_outputs();
    endtask

    typedef struct {
        logic [3:0] rows;
        int         col;
        logic [3:0] code;
        logic [3:0] hex;
    } kvec_t;

    kvec_t kv [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, n, mp0, kind, len;
        logic [3:0] ecol;

        hexmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        colseq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        kv[0] = '{4'b0010, 2, 4'b0110, 4'h6};
        kv[1] = '{4'b0110, 1, 4'b0101, 4'h5};
        kv[2] = '{4'b1000, 0, 4'b1100, 4'hE};
        kv[3] = '{4'b1000, 3, 4'b1111, 4'hD};
        kv[4] = '{4'b0100, 2, 4'b1010, 4'h9};
        kv[5] = '{4'b1001, 1, 4'b0001, 4'h2};
        lk_r = 0; lk_c = 0; m_pulses = 0; dut_pulses = 0;
        model_init();

        @(posedge clk);
        #1;
        do_reset(2);

        // Idle scan: each column held S cycles, wrapping.
        p0 = dut_pulses;
        for (int k = 1; k <= 40; k++) begin
            step();
            check("idle_col_n", bus.col_n, colseq[(k / S) % 4]);
        end
        check("idle_pulses", dut_pulses - p0, 0);

        // Key vectors: press, expect one event with the right code/hex, then release.
        for (int i = 0; i < 6; i++) begin
            pmask = '0;
            for (int r = 0; r < 4; r++) if (kv[i].rows[r]) pmask[r*4 + kv[i].col] = 1'b1;
            p0 = dut_pulses;
            run_steps(50);
            ecol = 4'hF;
            ecol[kv[i].col] = 1'b0;
            check("vec_pulses", dut_pulses - p0, 1);
            check("vec_key_code", bus.key_code, kv[i].code);
            check("vec_key_hex", bus.key_hex, kv[i].hex);
            check("vec_key_held", bus.key_held, 1'b1);
            check("vec_col_frozen", bus.col_n, ecol);
            pmask = '0;
            p0 = dut_pulses;
            run_steps(30);
            check("vec_release_held", bus.key_held, 1'b0);
            check("vec_release_pulses", dut_pulses - p0, 0);
        end

        // Bouncy press on row0/col3: low runs of 3 never qualify; stable contact does once.
        p0 = dut_pulses;
        for (int i = 0; i < 24; i++) begin
            pmask = '0;
            pmask[3] = ((i / 3) % 2 == 0);
            step();
        end
        pmask = 16'h0008;
        run_steps(50);
        check("bounce_pulses", dut_pulses - p0, 1);
        check("bounce_key_hex", bus.key_hex, 4'hA);
        check("bounce_key_code", bus.key_code, 4'b0011);

        // Release with a 2-cycle re-contact glitch, then clean release.
        p0 = dut_pulses;
        pmask = '0;     run_steps(3);
        pmask = 16'h0008; run_steps(2);
        check("glitch_held", bus.key_held, 1'b1);
        pmask = '0;
        run_steps(D - 1);
        check("release_held_before", bus.key_held, 1'b1);
        run_steps(1);
        check("release_held_after", bus.key_held, 1'b0);
        check("release_resume_col", bus.col_n, 4'b1110);
        check("release_pulses", dut_pulses - p0, 0);

        // Reset four cycles into press debounce with the key still closed.
        pmask = 16'h0100;
        n = 0;
        while (mode != 1 && n < 40) begin step(); n++; end
        check("press_reached_in_bound", n < 40, 1'b1);
        run_steps(3);
        do_reset(2);
        p0 = dut_pulses;
        run_steps(30);
        check("post_reset_pulses", dut_pulses - p0, 1);
        check("post_reset_key_hex", bus.key_hex, 4'h7);
        check("post_reset_key_code", bus.key_code, 4'b1000);
        pmask = '0;
        run_steps(30);

        // Randomized key activity checked cycle by cycle against the model.
        p0 = dut_pulses;
        mp0 = m_pulses;
        for (int seg = 0; seg < 80; seg++) begin
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 40);
            case (kind)
                0: pmask = '0;
                1: pmask = 16'(1 << $urandom_range(0, 15));
                2: pmask = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
                default: pmask = 16'(1 << $urandom_range(0, 15));
            endcase
            for (int i = 0; i < len; i++) begin
                if (kind == 3 && $urandom_range(0, 3) == 0) pmask = (pmask == '0) ? 16'(1 << $urandom_range(0, 15)) : '0;
                step();
            end
        end
        check("random_pulse_total", dut_pulses - p0, m_pulses - mp0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
